ncc_peak_finder: RTL and testbench

NCC_PEAK_FINDER -- requirements
Module: ncc_peak_finder

---
 rtl/ncc_pkg.sv | 31 +++
 rtl/ncc_score_adder.sv | 73 +++++++
 rtl/ncc_peak_finder.sv | 136 +++++++++++++
 tb/tb_ncc_peak_finder.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ncc_pkg.sv
// ============================================================================
// Module   : ncc_pkg
// Purpose  : Shared types and constants for the NCC peak finder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ncc_pkg;

    localparam int c_WIN_COLS_DEFAULT = 640;
    localparam int c_WIN_ROWS_DEFAULT = 480;

    typedef logic signed [11:0] score_t;
    typedef logic signed [9:0]  part_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam score_t c_SCORE_MIN = 12'sh800;

    function automatic score_t sext_part(input part_t p);
        return {{2{p[9]}}, p};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ncc_score_adder.sv
// ============================================================================
// Module   : ncc_score_adder
// Purpose  : Two-stage registered adder tree summing 16 signed 8-bit
//            accumulators into a 12-bit score, with a valid/tag side pipe.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ncc_score_adder
    import ncc_pkg::*;
#(
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [7:0]       i_acc [16],
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    output score_t           o_score,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);

    part_t            w_part [4];
    part_t            r_part [4];
    logic             r_valid1;
    logic             r_valid2;
    logic [TAG_W-1:0] r_tag1;
    logic [TAG_W-1:0] r_tag2;
    score_t           r_score;

    always_comb begin
        for (int g = 0; g < 4; g++) begin
            w_part[g] = '0;
            for (int k = 0; k < 4; k++) begin
                w_part[g] = w_part[g] + {{2{i_acc[4*g+k][7]}}, i_acc[4*g+k]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid1 <= 1'b0;
            r_valid2 <= 1'b0;
        end else begin
            r_valid1 <= i_valid;
            r_valid2 <= r_valid1;
        end
    end

    // Data registers load only alongside a valid bit, so input gaps leave
    // in-flight samples untouched.
    always_ff @(posedge clk) begin
        if (i_valid) begin
            r_part <= w_part;
            r_tag1 <= i_tag;
        end
        if (r_valid1) begin
            r_score <= sext_part(r_part[0]) + sext_part(r_part[1])
                     + sext_part(r_part[2]) + sext_part(r_part[3]);
            r_tag2  <= r_tag1;
        end
    end

    assign o_valid = r_valid2;
    assign o_score = r_score;
    assign o_tag   = r_tag2;
    assign o_busy  = r_valid1 | r_valid2;

endmodule

`default_nettype wire

// File: rtl/ncc_peak_finder.sv
// ============================================================================
// Module   : ncc_peak_finder
// Purpose  : Raster-scans NCC accumulator samples and reports the position
//            of the strictly greatest score (earliest wins on ties).
// Revision : 1.0
// ============================================================================
`default_nettype none

module ncc_peak_finder
    import ncc_pkg::*;
#(
    parameter int WIN_COLS = c_WIN_COLS_DEFAULT,
    parameter int WIN_ROWS = c_WIN_ROWS_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        acc_valid,
    input  logic [7:0]                  accIn [16],
    output logic                        busy,
    output logic                        peak_valid,
    input  logic                        result_ack,
    output logic [11:0]                 peak_score,
    output logic [$clog2(WIN_COLS)-1:0] peak_x,
    output logic [$clog2(WIN_ROWS)-1:0] peak_y
);

    localparam int c_X_W   = $clog2(WIN_COLS);
    localparam int c_Y_W   = $clog2(WIN_ROWS);
    localparam int c_TAG_W = c_X_W + c_Y_W;
    localparam logic [c_X_W-1:0] c_X_LAST = c_X_W'(WIN_COLS - 1);
    localparam logic [c_Y_W-1:0] c_Y_LAST = c_Y_W'(WIN_ROWS - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_X_W-1:0]   r_x;
    logic [c_Y_W-1:0]   r_y;
    score_t             r_best;
    logic [c_X_W-1:0]   r_best_x;
    logic [c_Y_W-1:0]   r_best_y;

    logic               w_accept;
    logic               w_last;
    logic               w_sc_valid;
    score_t             w_sc_score;
    logic [c_TAG_W-1:0] w_sc_tag;
    logic               w_pipe_busy;

    assign w_accept = (r_state == ST_SCAN) && acc_valid;
    assign w_last   = w_accept && (r_x == c_X_LAST) && (r_y == c_Y_LAST);

    ncc_score_adder #(
        .TAG_W (c_TAG_W)
    ) u_adder (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_accept),
        .i_acc   (accIn),
        .i_tag   ({r_y, r_x}),
        .o_valid (w_sc_valid),
        .o_score (w_sc_score),
        .o_tag   (w_sc_tag),
        .o_busy  (w_pipe_busy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        peak_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                busy = 1'b1;
                if (w_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave once the last sample has been compared.
                busy = 1'b1;
                if (!w_pipe_busy) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                peak_valid = 1'b1;
                if (result_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_best   <= '0;
            r_best_x <= '0;
            r_best_y <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_x      <= '0;
            r_y      <= '0;
            r_best   <= c_SCORE_MIN;
            r_best_x <= '0;
            r_best_y <= '0;
        end else begin
            if (w_accept) begin
                if (r_x == c_X_LAST) begin
                    r_x <= '0;
                    r_y <= r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
            // Strict compare keeps the earliest position on ties.
            if (w_sc_valid && (w_sc_score > r_best)) begin
                r_best   <= w_sc_score;
                r_best_x <= w_sc_tag[c_X_W-1:0];
                r_best_y <= w_sc_tag[c_TAG_W-1:c_X_W];
            end
        end
    end

    assign peak_score = r_best;
    assign peak_x     = r_best_x;
    assign peak_y     = r_best_y;

endmodule

`default_nettype wire

// File: tb/tb_ncc_peak_finder.sv
// ============================================================================
// Module   : tb_ncc_peak_finder
// Purpose  : Scoreboard bench for ncc_peak_finder on a 4x2 search window.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ncc_peak_finder;

    localparam int WIN_COLS = 4;
    localparam int WIN_ROWS = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        acc_valid = 1'b0;
    logic        result_ack = 1'b0;
    logic [7:0]  acc_in [16];
    logic        busy;
    logic        peak_valid;
    logic [11:0] peak_score;
    logic [1:0]  peak_x;
    logic [0:0]  peak_y;

    always #5 clk = ~clk;

    ncc_peak_finder #(
        .WIN_COLS (WIN_COLS),
        .WIN_ROWS (WIN_ROWS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .acc_valid  (acc_valid),
        .accIn      (acc_in),
        .busy       (busy),
        .peak_valid (peak_valid),
        .result_ack (result_ack),
        .peak_score (peak_score),
        .peak_x     (peak_x),
        .peak_y     (peak_y)
    );

    typedef struct {
        logic [11:0] score;
        logic [1:0]  x;
        logic [0:0]  y;
    } exp_t;

    exp_t exp_q[$];
    exp_t last_exp;
    int   n_cmp = 0;
    int   n_err = 0;
    int   m_best, m_x, m_y, m_cx, m_cy;

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_best = -2048; m_x = 0; m_y = 0; m_cx = 0; m_cy = 0;
    endtask

    // One sample: entries all v, entry 0 offset by e; then gap idle cycles.
    task automatic send(input int v, input int e, input int gap, input bit model);
        int s;
        int t;
        t = v + e;
        for (int k = 0; k < 16; k++) acc_in[k] = v[7:0];
        acc_in[0] = t[7:0];
        acc_valid = 1'b1;
        if (model) begin
            s = 0;
            for (int k = 0; k < 16; k++) s += int'($signed(acc_in[k]));
            if (s > m_best) begin
                m_best = s; m_x = m_cx; m_y = m_cy;
            end
            m_cx++;
            if (m_cx == WIN_COLS) begin
                m_cx = 0; m_cy++;
            end
        end
        @(negedge clk);
        acc_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic finish_scan();
        exp_t e;
        e.score = m_best[11:0];
        e.x     = m_x[1:0];
        e.y     = m_y[0:0];
        exp_q.push_back(e);
    endtask

    task automatic wait_result(input int exp_lat);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (peak_valid !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (peak_valid !== 1'b1) begin
            n_err++;
            $display("FAIL result_timeout: peak_valid=%b after %0d cycles, required 1", peak_valid, cyc);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        if (exp_lat >= 0) begin
            n_cmp++;
            if (cyc != exp_lat) begin
                n_err++;
                $display("FAIL latency: got %0d cycles, required %0d", cyc, exp_lat);
            end
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: result with no expected entry");
            return;
        end
        e = exp_q.pop_front();
        last_exp = e;
        if (peak_score !== e.score) begin
            n_err++;
            $display("FAIL peak_score: got %0d, required %0d", $signed(peak_score), $signed(e.score));
        end
        n_cmp++;
        if (peak_x !== e.x) begin
            n_err++;
            $display("FAIL peak_x: got %0d, required %0d", peak_x, e.x);
        end
        n_cmp++;
        if (peak_y !== e.y) begin
            n_err++;
            $display("FAIL peak_y: got %0d, required %0d", peak_y, e.y);
        end
    endtask

    task automatic do_ack();
        result_ack = 1'b1;
        @(negedge clk);
        result_ack = 1'b0;
        n_cmp++;
        if (peak_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL ack_idle: peak_valid=%b busy=%b, required 0 0", peak_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || peak_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: busy=%b peak_valid=%b, required 0 0", busy, peak_valid);
        end
        n_cmp++;
        if (peak_score !== 12'd0 || peak_x !== 2'd0 || peak_y !== 1'd0) begin
            n_err++;
            $display("FAIL reset_outputs: score=%0d x=%0d y=%0d, required 0 0 0", peak_score, peak_x, peak_y);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        do_start();
        for (int i = 0; i < 8; i++) send((i == 6) ? 3 : 1, 0, 0, 1'b1);
        finish_scan();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL drain_busy: busy=%b, required 1", busy);
        end
        wait_result(3);
        do_ack();
    endtask

    task automatic test_all_min();
        do_start();
        for (int i = 0; i < 8; i++) send(-128, 0, 0, 1'b1);
        finish_scan();
        wait_result(3);
        do_ack();
    endtask

    task automatic test_tie();
        do_start();
        for (int i = 0; i < 8; i++) send(1, (i == 1 || i == 7) ? 4 : 0, 0, 1'b1);
        finish_scan();
        wait_result(3);
        do_ack();
    endtask

    task automatic test_gaps();
        send(9, 0, 1, 1'b0);
        do_start();
        for (int i = 0; i < 8; i++) send((i == 6) ? 3 : 1, 0, (i < 7) ? 2 : 0, 1'b1);
        finish_scan();
        wait_result(3);
        send(100, 0, 0, 1'b0);
        send(100, 0, 2, 1'b0);
        n_cmp++;
        if (peak_valid !== 1'b1 || peak_score !== last_exp.score ||
            peak_x !== last_exp.x || peak_y !== last_exp.y) begin
            n_err++;
            $display("FAIL done_ignore_acc: valid=%b score=%0d x=%0d y=%0d, required 1 %0d %0d %0d",
                     peak_valid, $signed(peak_score), peak_x, peak_y,
                     $signed(last_exp.score), last_exp.x, last_exp.y);
        end
        do_ack();
    endtask

    task automatic test_reset_mid_scan();
        int vals [8] = '{-1, 2, 5, 0, 7, -3, 7, 1};
        do_start();
        for (int i = 0; i < 5; i++) send(6, 0, 0, 1'b0);
        rst = 1'b1; acc_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; acc_valid = 1'b0; start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || peak_valid !== 1'b0 || peak_score !== 12'd0) begin
            n_err++;
            $display("FAIL mid_reset: busy=%b valid=%b score=%0d, required 0 0 0", busy, peak_valid, peak_score);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_priority_start: busy=%b, required 0", busy);
        end
        do_start();
        for (int i = 0; i < 8; i++) send(vals[i], 0, 0, 1'b1);
        finish_scan();
        wait_result(3);
        do_ack();
    endtask

    task automatic test_hold_and_ack_start();
        do_start();
        for (int i = 0; i < 8; i++) send((i == 3) ? 2 : -1, 0, 0, 1'b1);
        finish_scan();
        wait_result(3);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (peak_valid !== 1'b1 || peak_score !== last_exp.score ||
                peak_x !== last_exp.x || peak_y !== last_exp.y) begin
                n_err++;
                $display("FAIL hold_cycle%0d: valid=%b score=%0d x=%0d y=%0d, required 1 %0d %0d %0d",
                         c, peak_valid, $signed(peak_score), peak_x, peak_y,
                         $signed(last_exp.score), last_exp.x, last_exp.y);
            end
        end
        start = 1'b1;
        do_ack();
        start = 1'b0;
        send(5, 0, 1, 1'b0);
        n_cmp++;
        if (busy !== 1'b0 || peak_valid !== 1'b0) begin
            n_err++;
            $display("FAIL ack_start_no_scan: busy=%b valid=%b, required 0 0", busy, peak_valid);
        end
    endtask

    initial begin
        for (int k = 0; k < 16; k++) acc_in[k] = 8'd0;
        test_reset();
        test_back_to_back();
        test_all_min();
        test_tie();
        test_gaps();
        test_reset_mid_scan();
        test_hold_and_ack_start();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
